// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the memory
// request front-end (mem_req_ctrl and its request FIFO).
package mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } mem_state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/req_fifo.sv
// req_fifo: small synchronous FIFO of request bundles with
// full/empty flags and an occupancy count.
module req_fifo
  import mem_pkg::*;
#(
  parameter type T     = mem_req_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues requests, issues one memory command at a
// time, and returns read data or a timeout abort.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  mem_state_e            state_q;
  logic [TW-1:0]         tmo_q;
  logic                  rdy_q;
  logic                  mem_wr_q;
  logic                  mem_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic                  rsp_err_q;
  logic                  err_tmo_q;

  req_t                        req_in;
  req_t                        head;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  // rdy_q keeps req_ready low until the first edge after reset.
  assign req_ready = rdy_q && !full;
  assign push      = req_valid && req_ready;
  assign req_in    = {req_wr, req_addr, req_wdata};
  assign pop       = !empty &&
                     ((state_q == IDLE) ||
                      (state_q == RESP && rsp_ready));

  req_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (req_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      rdy_q       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        ISSUE: begin
          if (mem_response || tmo_q == TMO_LAST) begin
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            state_q     <= mem_wr_q ? IDLE : RESP;
            rsp_valid_q <= !mem_wr_q;
            rsp_addr_q  <= mem_wr_q ? '0 : mem_addr_q;
            rsp_rdata_q <= (mem_response && !mem_wr_q) ? mem_rdata : '0;
            rsp_err_q   <= !mem_response && !mem_wr_q;
            if (!mem_response) err_tmo_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A pop from IDLE or from an accepted RESP starts the next command.
      if (pop) begin
        state_q     <= ISSUE;
        tmo_q       <= '0;
        mem_wr_q    <= head.wr;
        mem_rd_q    <= !head.wr;
        mem_addr_q  <= head.addr;
        mem_wdata_q <= head.wr ? head.wdata : '0;
      end
    end
  end

  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_err     = rsp_err_q;
  assign err_timeout = err_tmo_q;
  assign busy        = (fifo_cnt != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench with a behavioural memory
// model and a reference memory array for expected read data.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_addr;
  logic        rsp_err;
  logic        mem_wr;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_response = 1'b0;
  logic        busy;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] mem_arr [16];
  logic        mem_hold = 1'b0;
  logic        rnd_mem = 1'b0;
  logic        rnd_ready = 1'b0;
  int          mem_delay = 1;
  int          wait_cnt = 0;

  mem_req_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_addr     (rsp_addr),
    .rsp_err      (rsp_err),
    .mem_wr       (mem_wr),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_response (mem_response),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory stand-in: answers each command after mem_delay cycles.
  always @(negedge clk) begin
    if (!reset) begin
      mem_response = 1'b0;
      wait_cnt = 0;
    end else begin
      check("wr_rd_onehot", {63'd0, mem_wr && mem_rd}, 64'd0);
      if (!mem_wr && !mem_rd)
        check("idle_bus_zero", {28'd0, mem_addr, mem_wdata}, 64'd0);
      if (mem_response) begin
        mem_response = 1'b0;
      end else if ((mem_wr || mem_rd) && !mem_hold) begin
        if (wait_cnt >= mem_delay) begin
          if (mem_wr) mem_arr[mem_addr] = mem_wdata;
          else mem_rdata = mem_arr[mem_addr];
          mem_response = 1'b1;
          wait_cnt = 0;
          if (rnd_mem) mem_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #2;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every accepted response is checked against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got addr %0h data %0h err %0b",
                 rsp_addr, rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (rsp_addr !== e.a || rsp_rdata !== e.d || rsp_err !== e.e) begin
          n_err++;
          $display("FAIL rsp: got a=%0h d=%0h e=%0b expected a=%0h d=%0h e=%0b",
                   rsp_addr, rsp_rdata, rsp_err, e.a, e.d, e.e);
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [3:0] a,
                      input logic [31:0] d, input logic terr);
    int t;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("req_accept_bound", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (wr) begin
      ref_mem[a] = d;
    end else begin
      e.a = a;
      e.d = terr ? 32'd0 : ref_mem[a];
      e.e = terr;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) check("idle_bound", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] v;
    int t;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      mem_arr[i] = v;
    end

    // Reset state
    #12;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_mem_cmd", {62'd0, mem_wr, mem_rd}, 64'd0);
    check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_req_ready", {63'd0, req_ready}, 64'd1);

    // Single write then read
    mem_delay = 2;
    send(1'b1, 4'd3, 32'h1234, 1'b0);
    @(posedge clk);
    #1;
    check("wr_issue", {27'd0, mem_wr, mem_addr, mem_wdata},
          {27'd0, 1'b1, 4'd3, 32'h1234});
    wait_idle();
    send(1'b0, 4'd3, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check("rd_issue", {59'd0, mem_rd, mem_addr}, {59'd0, 1'b1, 4'd3});
    wait_idle();

    // FIFO full and backpressure
    mem_delay = 1;
    mem_hold = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b0, 4'(i + 8), 32'd0, 1'b0);
    check("full_req_ready", {63'd0, req_ready}, 64'd0);
    check("full_busy", {63'd0, busy}, 64'd1);
    mem_hold = 1'b0;
    send(1'b0, 4'd13, 32'd0, 1'b0);
    wait_idle();

    // Response stall
    rsp_ready = 1'b0;
    send(1'b0, 4'd0, 32'd0, 1'b0);
    send(1'b0, 4'd1, 32'd0, 1'b0);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", {58'd0, rsp_valid, mem_rd, rsp_addr},
            {58'd0, 1'b1, 1'b0, 4'd0});
    end
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_next_issue", {59'd0, mem_rd, mem_addr}, {59'd0, 1'b1, 4'd1});
    wait_idle();

    // Timeout on a read of addr 7
    mem_hold = 1'b1;
    send(1'b0, 4'd7, 32'd0, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    check("tmo_last_cycle", {63'd0, mem_rd}, 64'd1);
    @(posedge clk);
    #1;
    check("tmo_abort", {59'd0, mem_rd, rsp_valid, rsp_err, err_timeout, 1'b0},
          {59'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("tmo_rdata", {32'd0, rsp_rdata}, 64'd0);
    mem_hold = 1'b0;
    wait_idle();
    send(1'b1, 4'd5, 32'hCAFE_0005, 1'b0);
    send(1'b0, 4'd5, 32'd0, 1'b0);
    wait_idle();
    check("tmo_sticky", {63'd0, err_timeout}, 64'd1);

    // Reset mid-command; writes keep the reference contents unchanged
    mem_hold = 1'b1;
    send(1'b1, 4'd2, ref_mem[2], 1'b0);
    send(1'b1, 4'd9, ref_mem[9], 1'b0);
    @(posedge clk);
    #3;
    check("pre_rst_cmd", {63'd0, mem_wr}, 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst", {60'd0, mem_wr, mem_rd, req_ready, busy}, 64'd0);
    check("mid_rst_err", {63'd0, err_timeout}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_hold = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rel_ready", {63'd0, req_ready}, 64'd1);

    // Sweep with random data, delays and backpressure
    rnd_mem = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), $urandom, 1'b0);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 32'd0, 1'b0);
    wait_idle();
    rnd_ready = 1'b0;
    #3;
    rsp_ready = 1'b1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
